hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised successor to the pipeline's combinational hazard/forwarding logic. It sits beside the ID/EX boundary and tracks per-register pending writes with latency countdowns. From these it generates load-use and multi-cycle stalls, WAW stalls and structural stalls for a single multi-cycle unit. It also produces EX-stage forward selects and rolls back scoreboard state for the instruction squashed by a taken branch.

## Interface
- NUM_REGS, 32, architectural registers; x0 is never tracked.
- REG_ADDR_W, 5, register index width; must satisfy 2**REG_ADDR_W ≥ NUM_REGS.
- MAX_LAT, 8, maximum result latency in cycles.
- LAT_W, $clog2(MAX_LAT+1), countdown width.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_ADDR_W  ID source indices.
- id_uses_rs1, id_uses_rs2  in  1  source is actually read.
- id_rd  in  REG_ADDR_W  ID destination.
- id_regwrite  in  1  ID instruction writes id_rd.
- id_lat  in  LAT_W  cycles from issue until result is forwardable from MEM. ALU=1, load=2, multi-cycle=N.
- id_is_mc  in  1  ID instruction uses the multi-cycle unit.
- ex_rs1, ex_rs2  in  REG_ADDR_W  EX-stage sources.
- rd_MEM, RegWrite_MEM, rd_WB, RegWrite_WB  in  REG_ADDR_W/1  downstream writers.
- PCSrc  in  1  taken branch resolved in MEM.
- stall  out  1  hold PC and IF/ID; insert bubble into EX.
- flush  out  1  squash IF/ID and ID/EX (equals PCSrc).
- forwardA, forwardB  out  2  EX operand selects.
- mc_busy  out  1  multi-cycle unit occupied.
- mc_kill  out  1  abort the multi-cycle op issued last cycle.

## Operation
- State:
  - pending[1..NUM_REGS-1] (LAT_W each).
  - mc_cnt (LAT_W).
  - ex_slot {valid, rd, prev_cnt, is_mc}.
- Latency normalisation: lat_n = max(1, min(id_lat, MAX_LAT)).
- Hazard conditions, for used sources with index ≠ 0:
  - RAW: pending[rs] > 1.
  - WAW: id_regwrite, id_rd ≠ 0, and pending[id_rd] > lat_n.
  - Structural: id_is_mc and mc_cnt > 1.
- stall = id_valid & ~PCSrc & (RAW | WAW | structural).
- issue = id_valid & ~stall & ~PCSrc.
- Each cycle:
  - Every nonzero pending entry decrements by 1. Counters saturate at 0.
  - mc_cnt decrements likewise.
- On issue with id_regwrite and id_rd ≠ 0:
  - pending[id_rd] ← lat_n; this overrides the decrement.
  - ex_slot ← {1, id_rd, sat_dec(old pending[id_rd]), id_is_mc}.
- On issue with id_is_mc: mc_cnt ← lat_n. Any other cycle: ex_slot.valid ← 0.
- On PCSrc with ex_slot.valid:
  - pending[ex_slot.rd] ← sat_dec(ex_slot.prev_cnt).
  - If ex_slot.is_mc: mc_cnt ← 0 and mc_kill = 1.
  - ex_slot.valid ← 0.
- Forward selects (per operand, combinational):
  - FWD_MEM if RegWrite_MEM & rd_MEM ≠ 0 & rd_MEM == ex_rs.
  - Else FWD_WB under the same test on the WB signals.
  - Else FWD_RF.
  - MEM has priority over WB.
- mc_busy = (mc_cnt ≠ 0).

## Timing
- Reset (async assert, sync-safe deassert):
  - pending, mc_cnt and ex_slot are all zero.
  - stall=0, flush=0, forwardA/B=FWD_RF, mc_busy=0, mc_kill=0.
- stall, flush, forwardA/B and mc_kill are combinational from current state and inputs; there is no added latency.
- Scoreboard updates take effect the cycle after the issue edge.
- Load-use: exactly 1 stall cycle. ALU-to-ALU: 0 stall cycles. Multi-cycle with latency N: N−1 stall cycles for a dependent instruction.
- Simultaneous events:
  - PCSrc overrides stall; the ID instruction is not issued.
  - An issue write overrides the decrement of the same entry.
  - A flush rollback and a same-cycle decrement of other entries both apply.
- A reset mid-stall clears everything; the next cycle treats ID as having no hazards.

## Structure
- Package hazard_pkg:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - LAT_ALU=1, LAT_LOAD=2.
  - ex_slot struct typedef.
- Sub-module hazard_fwd_sel: combinational compare per operand, instantiated twice (A, B).

## Test plan
- Reset with PCSrc=1 and id_valid=1 applied → all outputs at reset values. After release, pending[*]=0 and mc_busy=0.
- add x5 (lat 1), then dependent sub reading x5 → stall=0. Next cycle forwardA=FWD_MEM; the cycle after, forwardA=FWD_WB.
- lw x6 (lat 2), then dependent add on rs2=x6 → stall=1 for exactly one cycle, then issue with forwardB=FWD_MEM.
- mc op writing x7 with id_lat=5, then dependent add → stall held 4 cycles. An independent second mc op stalls until mc_cnt ≤ 1.
- mc op x8 (lat 6), then ALU op x8 (lat 1) → WAW stall until pending[x8] ≤ 1.
- Branch taken (PCSrc=1) the cycle after issuing lw x9, with prior pending[x9]=0:
  - flush=1 and mc_kill=0.
  - pending[x9]=0 next cycle.
  - A following reader of x9 sees stall=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types and constants for the hazard scoreboard slice.
//   fwd_sel_e  : EX operand source select (register file, WB, MEM).
//   LAT_ALU    : result latency of a single-cycle ALU op.
//   LAT_LOAD   : result latency of a load.
//   ex_slot_t  : bookkeeping for the instruction issued last cycle, kept so
//                a taken branch can undo its scoreboard write.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

    // Field widths of the EX slot. They bound REG_ADDR_W and LAT_W of any
    // scoreboard instance that uses this package.
    localparam int SLOT_RD_W  = 5;
    localparam int SLOT_CNT_W = 4;

    typedef struct packed {
        logic                  valid;
        logic [SLOT_RD_W-1:0]  rd;
        logic [SLOT_CNT_W-1:0] prev_cnt;
        logic                  is_mc;
    } ex_slot_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel
// Combinational EX operand forward select for one source operand.
//   ex_rs        : EX-stage source register index.
//   rd_mem/regwrite_mem : destination and write enable of the MEM-stage op.
//   rd_wb/regwrite_wb   : destination and write enable of the WB-stage op.
//   sel          : FWD_MEM, FWD_WB or FWD_RF; MEM wins over WB, x0 never
//                  forwards.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] rd_mem,
    input  logic                  regwrite_mem,
    input  logic [REG_ADDR_W-1:0] rd_wb,
    input  logic                  regwrite_wb,
    output logic [1:0]            sel
);

    always_comb begin
        sel = FWD_RF;
        if (regwrite_mem && (rd_mem != '0) && (rd_mem == ex_rs)) begin
            sel = FWD_MEM;
        end else if (regwrite_wb && (rd_wb != '0) && (rd_wb == ex_rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Per-register latency scoreboard beside the ID/EX boundary.
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset.
//   id_*             : instruction currently in ID (sources, destination,
//                      result latency, multi-cycle unit use).
//   ex_rs1/ex_rs2    : EX-stage sources for forwarding.
//   rd_MEM/RegWrite_MEM, rd_WB/RegWrite_WB : downstream writers.
//   PCSrc            : taken branch resolved in MEM.
//   stall            : hold PC and IF/ID, bubble into EX.
//   flush            : squash IF/ID and ID/EX.
//   forwardA/B       : EX operand selects.
//   mc_busy          : multi-cycle unit occupied.
//   mc_kill          : abort the multi-cycle op issued last cycle.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MAX_LAT    = 8,
    parameter int LAT_W      = $clog2(MAX_LAT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic [LAT_W-1:0]      id_lat,
    input  logic                  id_is_mc,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] rd_MEM,
    input  logic                  RegWrite_MEM,
    input  logic [REG_ADDR_W-1:0] rd_WB,
    input  logic                  RegWrite_WB,
    input  logic                  PCSrc,
    output logic                  stall,
    output logic                  flush,
    output logic [1:0]            forwardA,
    output logic [1:0]            forwardB,
    output logic                  mc_busy,
    output logic                  mc_kill
);

    // Every encodable index gets an entry so ID indices never fall outside
    // the array; x0 and indices >= NUM_REGS are held at zero.
    localparam int NUM_IDX = 2 ** REG_ADDR_W;

    logic [LAT_W-1:0]      pending_reg  [NUM_IDX];
    logic [LAT_W-1:0]      pending_next [NUM_IDX];
    logic [LAT_W-1:0]      mc_cnt_reg;
    logic [LAT_W-1:0]      mc_cnt_next;
    ex_slot_t              slot_reg;
    ex_slot_t              slot_next;

    logic [LAT_W-1:0]      lat_n;
    logic                  raw_rs1;
    logic                  raw_rs2;
    logic                  waw;
    logic                  struct_haz;
    logic                  issue;
    logic                  issue_wr;
    logic                  rollback;
    logic [REG_ADDR_W-1:0] slot_rd;
    logic                  fwd_en;

    function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    // Clamp the requested latency into [LAT_ALU, MAX_LAT].
    always_comb begin
        if (id_lat < LAT_W'(LAT_ALU)) begin
            lat_n = LAT_W'(LAT_ALU);
        end else if (id_lat > LAT_W'(MAX_LAT)) begin
            lat_n = LAT_W'(MAX_LAT);
        end else begin
            lat_n = id_lat;
        end
    end

    // A count of 1 means the result is forwardable from MEM next cycle, so
    // only counts above 1 block a reader.
    assign raw_rs1    = id_uses_rs1 && (id_rs1 != '0) && (pending_reg[id_rs1] > LAT_W'(1));
    assign raw_rs2    = id_uses_rs2 && (id_rs2 != '0) && (pending_reg[id_rs2] > LAT_W'(1));
    // Younger writer must not complete before an older one to the same reg.
    assign waw        = id_regwrite && (id_rd != '0) && (pending_reg[id_rd] > lat_n);
    assign struct_haz = id_is_mc && (mc_cnt_reg > LAT_W'(1));

    assign stall    = id_valid && !PCSrc && (raw_rs1 || raw_rs2 || waw || struct_haz);
    assign issue    = id_valid && !PCSrc && !stall;
    assign issue_wr = issue && id_regwrite && (id_rd != '0);
    assign rollback = PCSrc && slot_reg.valid;
    assign slot_rd  = REG_ADDR_W'(slot_reg.rd);

    assign flush    = PCSrc && rst_n;
    assign mc_kill  = rollback && slot_reg.is_mc;
    assign mc_busy  = (mc_cnt_reg != '0);

    // Per-entry next value: issue write beats rollback beats decrement. An
    // issue and a rollback never coincide because PCSrc blocks issue.
    for (genvar gi = 0; gi < NUM_IDX; gi++) begin : g_entry
        if ((gi == 0) || (gi >= NUM_REGS)) begin : g_untracked
            assign pending_next[gi] = '0;
        end else begin : g_tracked
            assign pending_next[gi] =
                (issue_wr && (id_rd == REG_ADDR_W'(gi))) ? lat_n :
                (rollback && (slot_rd == REG_ADDR_W'(gi))) ? sat_dec(LAT_W'(slot_reg.prev_cnt)) :
                sat_dec(pending_reg[gi]);
        end
    end

    always_comb begin
        mc_cnt_next = sat_dec(mc_cnt_reg);
        if (issue && id_is_mc) begin
            mc_cnt_next = lat_n;
        end
        if (mc_kill) begin
            mc_cnt_next = '0;
        end
    end

    // The slot also records multi-cycle ops that write no register, so a
    // branch can still kill them; rd stays 0 and its rollback is a no-op.
    always_comb begin
        slot_next = '0;
        if (issue && (issue_wr || id_is_mc)) begin
            slot_next.valid = 1'b1;
            slot_next.is_mc = id_is_mc;
            if (issue_wr) begin
                slot_next.rd       = SLOT_RD_W'(id_rd);
                slot_next.prev_cnt = SLOT_CNT_W'(sat_dec(pending_reg[id_rd]));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_IDX; i++) begin
                pending_reg[i] <= '0;
            end
            mc_cnt_reg <= '0;
            slot_reg   <= '0;
        end else begin
            for (int i = 0; i < NUM_IDX; i++) begin
                pending_reg[i] <= pending_next[i];
            end
            mc_cnt_reg <= mc_cnt_next;
            slot_reg   <= slot_next;
        end
    end

    // Forwarding is held at the register file while reset is asserted.
    assign fwd_en = rst_n;

    hazard_fwd_sel #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_a (
        .ex_rs        (ex_rs1),
        .rd_mem       (rd_MEM),
        .regwrite_mem (RegWrite_MEM && fwd_en),
        .rd_wb        (rd_WB),
        .regwrite_wb  (RegWrite_WB && fwd_en),
        .sel          (forwardA)
    );

    hazard_fwd_sel #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_b (
        .ex_rs        (ex_rs2),
        .rd_mem       (rd_MEM),
        .regwrite_mem (RegWrite_MEM && fwd_en),
        .rd_wb        (rd_WB),
        .regwrite_wb  (RegWrite_WB && fwd_en),
        .sel          (forwardB)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Directed scenarios plus a randomized instruction stream checked against a
// time-stamped reference model of the scoreboard.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int ML = 8;
    localparam int LW = 4;

    logic          clk;
    logic          rst_n;
    logic          id_valid;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_uses_rs1, id_uses_rs2, id_regwrite, id_is_mc;
    logic [LW-1:0] id_lat;
    logic [AW-1:0] ex_rs1, ex_rs2, rd_MEM, rd_WB;
    logic          RegWrite_MEM, RegWrite_WB, PCSrc;
    logic          stall, flush, mc_busy, mc_kill;
    logic [1:0]    forwardA, forwardB;

    int vectors = 0;
    int errors  = 0;

    hazard_scoreboard #(
        .NUM_REGS(NR), .REG_ADDR_W(AW), .MAX_LAT(ML), .LAT_W(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_lat(id_lat),
        .id_is_mc(id_is_mc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .rd_MEM(rd_MEM), .RegWrite_MEM(RegWrite_MEM),
        .rd_WB(rd_WB), .RegWrite_WB(RegWrite_WB), .PCSrc(PCSrc),
        .stall(stall), .flush(flush), .forwardA(forwardA), .forwardB(forwardB),
        .mc_busy(mc_busy), .mc_kill(mc_kill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each register remembers when its latency was last set and to what;
    // its outstanding count is that latency minus elapsed cycles.
    int now;
    int rec_t [NR];
    int rec_l [NR];
    int mc_t, mc_l;
    bit ls_valid, ls_is_mc;
    int ls_rd, ls_old_t, ls_old_l;
    bit e_stall, e_flush, e_kill, e_busy;
    logic [1:0] e_fa, e_fb;

    function automatic int remaining(int l, int t, int at);
        int v;
        v = l - (at - t);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic int lnorm(int l);
        if (l < 1) return 1;
        if (l > ML) return ML;
        return l;
    endfunction

    function automatic logic [1:0] fwd_exp(int rs, int mrd, bit mw, int wrd, bit ww);
        if (mw && mrd != 0 && mrd == rs) return FWD_MEM;
        if (ww && wrd != 0 && wrd == rs) return FWD_WB;
        return FWD_RF;
    endfunction

    function automatic int pend(int r);
        if (r == 0) return 0;
        return remaining(rec_l[r], rec_t[r], now);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            rec_t[r] = now;
            rec_l[r] = 0;
        end
        mc_t = now; mc_l = 0;
        ls_valid = 0; ls_is_mc = 0; ls_rd = 0;
    endtask

    task automatic model_eval();
        bit raw, waw, strc;
        int ln;
        ln   = lnorm(int'(id_lat));
        raw  = (id_uses_rs1 && pend(int'(id_rs1)) > 1) || (id_uses_rs2 && pend(int'(id_rs2)) > 1);
        waw  = id_regwrite && id_rd != 0 && pend(int'(id_rd)) > ln;
        strc = id_is_mc && remaining(mc_l, mc_t, now) > 1;
        e_stall = id_valid && !PCSrc && (raw || waw || strc);
        e_flush = PCSrc;
        e_kill  = PCSrc && ls_valid && ls_is_mc;
        e_busy  = remaining(mc_l, mc_t, now) != 0;
        e_fa = fwd_exp(int'(ex_rs1), int'(rd_MEM), RegWrite_MEM, int'(rd_WB), RegWrite_WB);
        e_fb = fwd_exp(int'(ex_rs2), int'(rd_MEM), RegWrite_MEM, int'(rd_WB), RegWrite_WB);
    endtask

    task automatic model_commit();
        bit iss, wr;
        int rd, ln;
        iss = id_valid && !PCSrc && !e_stall;
        rd  = int'(id_rd);
        wr  = id_regwrite && rd != 0;
        ln  = lnorm(int'(id_lat));
        if (PCSrc && ls_valid) begin
            if (ls_rd != 0) begin
                rec_t[ls_rd] = ls_old_t;
                rec_l[ls_rd] = ls_old_l;
            end
            if (ls_is_mc) begin
                mc_t = now + 1; mc_l = 0;
            end
        end
        ls_valid = 0;
        if (iss && (wr || id_is_mc)) begin
            ls_valid = 1;
            ls_is_mc = id_is_mc;
            ls_rd    = wr ? rd : 0;
            if (wr) begin
                ls_old_t = rec_t[rd];
                ls_old_l = rec_l[rd];
                rec_t[rd] = now + 1;
                rec_l[rd] = ln;
            end
            if (id_is_mc) begin
                mc_t = now + 1; mc_l = ln;
            end
        end
        now++;
    endtask

    // Advance one clock: model consumes current inputs, DUT samples them.
    task automatic tick();
        model_eval();
        model_commit();
        @(posedge clk);
        #2;
    endtask

    task automatic set_idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rd = 0; id_regwrite = 0; id_lat = 0; id_is_mc = 0;
        ex_rs1 = 0; ex_rs2 = 0; rd_MEM = 0; RegWrite_MEM = 0;
        rd_WB = 0; RegWrite_WB = 0; PCSrc = 0;
    endtask

    task automatic set_id(int rd, int rs1, int rs2, bit u1, bit u2, bit wr, int lat, bit mc);
        id_valid = 1; id_rd = AW'(rd); id_rs1 = AW'(rs1); id_rs2 = AW'(rs2);
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_regwrite = wr;
        id_lat = LW'(lat); id_is_mc = mc;
    endtask

    task automatic drain();
        set_idle();
        repeat (10) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 0;
        set_idle();
        id_valid = 1; PCSrc = 1; id_is_mc = 1; id_rs1 = 3; id_uses_rs1 = 1;
        RegWrite_MEM = 1; rd_MEM = 3; RegWrite_WB = 1; rd_WB = 4;
        ex_rs1 = 3; ex_rs2 = 4;
        now = 0;
        model_reset();
        #12;
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", stall); end
        vectors++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b want=0", flush); end
        vectors++; if (forwardA !== FWD_RF) begin errors++; $display("FAIL reset_fwdA got=%b want=%b", forwardA, FWD_RF); end
        vectors++; if (forwardB !== FWD_RF) begin errors++; $display("FAIL reset_fwdB got=%b want=%b", forwardB, FWD_RF); end
        vectors++; if (mc_busy !== 1'b0) begin errors++; $display("FAIL reset_mc_busy got=%b want=0", mc_busy); end
        vectors++; if (mc_kill !== 1'b0) begin errors++; $display("FAIL reset_mc_kill got=%b want=0", mc_kill); end
        @(posedge clk); #2;
        rst_n = 1;
        set_idle();
        model_reset();
        // Every register reads as free right after reset.
        for (int r = 1; r < NR; r++) begin
            set_id(0, r, r, 1, 1, 0, 1, 0);
            #1;
            vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL post_reset_free x%0d stall got=%b want=0", r, stall); end
        end
        vectors++; if (mc_busy !== 1'b0) begin errors++; $display("FAIL post_reset_mc_busy got=%b want=0", mc_busy); end
        $display("reset: outputs and scoreboard clear");
        set_idle();
        tick();
    endtask

    task automatic test_alu_forward();
        drain();
        set_id(5, 1, 2, 1, 1, 1, LAT_ALU, 0); #1;
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_add_stall got=%b want=0", stall); end
        tick();
        set_id(10, 5, 3, 1, 1, 1, LAT_ALU, 0); #1;
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_dep_stall got=%b want=0", stall); end
        tick();
        set_idle(); ex_rs1 = 5; ex_rs2 = 3; rd_MEM = 5; RegWrite_MEM = 1; #1;
        vectors++; if (forwardA !== FWD_MEM) begin errors++; $display("FAIL alu_fwdA_mem got=%b want=%b", forwardA, FWD_MEM); end
        vectors++; if (forwardB !== FWD_RF) begin errors++; $display("FAIL alu_fwdB_rf got=%b want=%b", forwardB, FWD_RF); end
        tick();
        ex_rs1 = 5; ex_rs2 = 10; rd_MEM = 10; RegWrite_MEM = 1; rd_WB = 5; RegWrite_WB = 1; #1;
        vectors++; if (forwardA !== FWD_WB) begin errors++; $display("FAIL alu_fwdA_wb got=%b want=%b", forwardA, FWD_WB); end
        vectors++; if (forwardB !== FWD_MEM) begin errors++; $display("FAIL alu_fwdB_mem got=%b want=%b", forwardB, FWD_MEM); end
        tick();
        // MEM beats WB on the same register; x0 never forwards.
        ex_rs1 = 7; ex_rs2 = 0; rd_MEM = 7; RegWrite_MEM = 1; rd_WB = 7; RegWrite_WB = 1; #1;
        vectors++; if (forwardA !== FWD_MEM) begin errors++; $display("FAIL fwd_priority got=%b want=%b", forwardA, FWD_MEM); end
        rd_MEM = 0; rd_WB = 0; #1;
        vectors++; if (forwardB !== FWD_RF) begin errors++; $display("FAIL fwd_x0 got=%b want=%b", forwardB, FWD_RF); end
        $display("alu_forward: add/sub chain, MEM then WB forward");
        set_idle();
        tick();
    endtask

    // Holds the ID instruction until it issues; returns stall cycles seen.
    task automatic count_stalls(output int n);
        n = 0;
        #1;
        while (stall === 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        vectors++; if (n >= 20) begin errors++; $display("FAIL stall_timeout got=%0d cycles want<20", n); end
    endtask

    task automatic test_load_use();
        int n;
        drain();
        set_id(6, 1, 0, 1, 0, 1, LAT_LOAD, 0); tick();
        set_id(15, 1, 6, 1, 1, 1, LAT_ALU, 0);
        count_stalls(n);
        vectors++; if (n !== 1) begin errors++; $display("FAIL load_use_stalls got=%0d want=1", n); end
        tick();
        set_idle(); ex_rs1 = 1; ex_rs2 = 6; rd_MEM = 6; RegWrite_MEM = 1; #1;
        vectors++; if (forwardB !== FWD_MEM) begin errors++; $display("FAIL load_use_fwdB got=%b want=%b", forwardB, FWD_MEM); end
        $display("load_use: %0d stall cycle(s)", n);
        set_idle();
        tick();
    endtask

    task automatic test_mc();
        int n;
        drain();
        set_id(7, 1, 0, 1, 0, 1, 5, 1); tick();
        set_id(14, 7, 0, 1, 0, 1, LAT_ALU, 0);
        count_stalls(n);
        vectors++; if (n !== 4) begin errors++; $display("FAIL mc_dep_stalls got=%0d want=4", n); end
        tick();
        set_id(11, 1, 0, 1, 0, 1, 5, 1); #1;
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL mc_second_issue stall got=%b want=0", stall); end
        tick();
        set_id(12, 1, 0, 1, 0, 1, 3, 1); #1;
        vectors++; if (mc_busy !== 1'b1) begin errors++; $display("FAIL mc_busy got=%b want=1", mc_busy); end
        count_stalls(n);
        vectors++; if (n !== 4) begin errors++; $display("FAIL mc_struct_stalls got=%0d want=4", n); end
        $display("mc: dependent and structural stall counts checked");
        tick();
        set_idle();
    endtask

    task automatic test_waw();
        int n;
        drain();
        set_id(8, 0, 0, 0, 0, 1, 6, 1); tick();
        set_id(8, 0, 0, 0, 0, 1, LAT_ALU, 0);
        count_stalls(n);
        vectors++; if (n !== 5) begin errors++; $display("FAIL waw_stalls got=%0d want=5", n); end
        tick();
        // The ALU write replaced the long count, so a reader is free.
        set_id(16, 8, 0, 1, 0, 1, LAT_ALU, 0); #1;
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_override got=%b want=0", stall); end
        $display("waw: %0d stall cycles", n);
        set_idle();
        tick();
    endtask

    task automatic test_branch();
        drain();
        set_id(9, 1, 0, 1, 0, 1, LAT_LOAD, 0); tick();
        set_id(17, 9, 0, 1, 0, 1, LAT_ALU, 0); PCSrc = 1; #1;
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL br_stall got=%b want=0", stall); end
        vectors++; if (flush !== 1'b1) begin errors++; $display("FAIL br_flush got=%b want=1", flush); end
        vectors++; if (mc_kill !== 1'b0) begin errors++; $display("FAIL br_mc_kill got=%b want=0", mc_kill); end
        tick();
        PCSrc = 0; #1;
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL br_reader_stall got=%b want=0", stall); end
        drain();
        // Squashed multi-cycle write: the unit and x9 are released.
        set_id(9, 1, 0, 1, 0, 1, 6, 1); tick();
        set_idle(); PCSrc = 1; #1;
        vectors++; if (mc_kill !== 1'b1) begin errors++; $display("FAIL br_mc_kill_mc got=%b want=1", mc_kill); end
        tick();
        set_id(18, 9, 0, 1, 0, 1, 3, 1); #1;
        vectors++; if (mc_busy !== 1'b0) begin errors++; $display("FAIL br_mc_released got=%b want=0", mc_busy); end
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL br_mc_reader got=%b want=0", stall); end
        $display("branch: flush, rollback and mc kill checked");
        set_idle();
        tick();
    endtask

    task automatic test_reset_mid_stall();
        drain();
        set_id(13, 1, 0, 1, 0, 1, LAT_LOAD, 0); tick();
        set_id(19, 13, 0, 1, 0, 1, LAT_ALU, 0); #1;
        vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_stall_before got=%b want=1", stall); end
        rst_n = 0; #1;
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_stall_async got=%b want=0", stall); end
        @(posedge clk); #2;
        rst_n = 1;
        model_reset();
        #1;
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_stall_after got=%b want=0", stall); end
        $display("reset_mid_stall: hazard cleared");
        set_idle();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            id_valid    = ($urandom_range(0, 9) < 8);
            id_rs1      = AW'($urandom_range(0, 7));
            id_rs2      = AW'($urandom_range(0, 7));
            id_uses_rs1 = $urandom_range(0, 1);
            id_uses_rs2 = $urandom_range(0, 1);
            id_rd       = AW'($urandom_range(0, 7));
            id_regwrite = ($urandom_range(0, 9) < 8);
            id_lat      = LW'($urandom_range(0, 11));
            id_is_mc    = ($urandom_range(0, 9) < 2);
            PCSrc       = ($urandom_range(0, 99) < 8);
            ex_rs1      = AW'($urandom_range(0, 7));
            ex_rs2      = AW'($urandom_range(0, 7));
            rd_MEM      = AW'($urandom_range(0, 7));
            RegWrite_MEM = $urandom_range(0, 1);
            rd_WB       = AW'($urandom_range(0, 7));
            RegWrite_WB = $urandom_range(0, 1);
            model_eval();
            #1;
            vectors++; if (stall !== e_stall) begin errors++; $display("FAIL rnd_stall c=%0d got=%b want=%b", c, stall, e_stall); end
            vectors++; if (flush !== e_flush) begin errors++; $display("FAIL rnd_flush c=%0d got=%b want=%b", c, flush, e_flush); end
            vectors++; if (forwardA !== e_fa) begin errors++; $display("FAIL rnd_fwdA c=%0d got=%b want=%b", c, forwardA, e_fa); end
            vectors++; if (forwardB !== e_fb) begin errors++; $display("FAIL rnd_fwdB c=%0d got=%b want=%b", c, forwardB, e_fb); end
            vectors++; if (mc_busy !== e_busy) begin errors++; $display("FAIL rnd_mc_busy c=%0d got=%b want=%b", c, mc_busy, e_busy); end
            vectors++; if (mc_kill !== e_kill) begin errors++; $display("FAIL rnd_mc_kill c=%0d got=%b want=%b", c, mc_kill, e_kill); end
            tick();
        end
        $display("random: 600 cycles compared against model");
        set_idle();
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_load_use();
        test_mc();
        test_waw();
        test_branch();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
